tinyrv1_scycle_proc: RTL and testbench

//  Single-cycle TinyRV1 (RISC-V subset) processor core: fetch, decode, execute, memory and

---
 rtl/tinyrv1_scycle_proc.sv | 187 ++++++++++++++++++
 tb/tb_tinyrv1_scycle_proc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyrv1_scycle_proc.sv
// Single-cycle TinyRV1 core: fetch, decode, execute, memory and writeback in one clock.
// Instruction and data ports are combinational; a writeback trace is exported.
module tinyrv1_scycle_proc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemreq_val,
  output logic [31:0] imemreq_addr,
  input  logic [31:0] imemresp_data,
  output logic        dmemreq_val,
  output logic        dmemreq_type,
  output logic [31:0] dmemreq_addr,
  output logic [31:0] dmemreq_wdata,
  input  logic [31:0] dmemresp_rdata,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic        trace_val,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] out0_q, out1_q, out2_q;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] csr;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  assign opcode = imemresp_data[6:0];
  assign rd     = imemresp_data[11:7];
  assign funct3 = imemresp_data[14:12];
  assign rs1    = imemresp_data[19:15];
  assign rs2    = imemresp_data[24:20];
  assign funct7 = imemresp_data[31:25];
  assign csr    = imemresp_data[31:20];

  assign imm_i = {{20{imemresp_data[31]}}, imemresp_data[31:20]};
  assign imm_s = {{20{imemresp_data[31]}}, imemresp_data[31:25], imemresp_data[11:7]};
  assign imm_b = {{20{imemresp_data[31]}}, imemresp_data[7], imemresp_data[30:25],
                  imemresp_data[11:8], 1'b0};
  assign imm_j = {{12{imemresp_data[31]}}, imemresp_data[19:12], imemresp_data[20],
                  imemresp_data[30:21], 1'b0};

  // x0 is hardwired to zero on the read side
  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  logic        wb_en;
  logic [31:0] wb_data;
  logic        dmem_val, dmem_wr;
  logic [31:0] dmem_addr;
  logic [2:0]  csr_we;

  // Decode and execute: next PC, writeback, data access and CSR write strobes
  always_comb begin
    pc_d      = pc_plus4;
    wb_en     = 1'b0;
    wb_data   = 32'd0;
    dmem_val  = 1'b0;
    dmem_wr   = 1'b0;
    dmem_addr = rs1_val + imm_i;
    csr_we    = 3'b000;
    case (opcode)
      OpReg: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          wb_en   = 1'b1;
          wb_data = rs1_val + rs2_val;
        end else if (funct3 == 3'b000 && funct7 == 7'b0000001) begin
          wb_en   = 1'b1;
          wb_data = rs1_val * rs2_val;
        end
      end
      OpImm: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = rs1_val + imm_i;
        end
      end
      OpLoad: begin
        if (funct3 == 3'b010) begin
          dmem_val = 1'b1;
          wb_en    = 1'b1;
          wb_data  = dmemresp_rdata;
        end
      end
      OpStore: begin
        if (funct3 == 3'b010) begin
          dmem_val  = 1'b1;
          dmem_wr   = 1'b1;
          dmem_addr = rs1_val + imm_s;
        end
      end
      OpJal: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_d    = pc_q + imm_j;
      end
      OpJalr: begin
        if (funct3 == 3'b000) pc_d = rs1_val;
      end
      OpBranch: begin
        if (funct3 == 3'b001 && rs1_val != rs2_val) pc_d = pc_q + imm_b;
      end
      OpSystem: begin
        if (funct3 == 3'b010) begin
          case (csr)
            12'hFC2: begin wb_en = 1'b1; wb_data = in0; end
            12'hFC3: begin wb_en = 1'b1; wb_data = in1; end
            12'hFC4: begin wb_en = 1'b1; wb_data = in2; end
            default: ;
          endcase
        end else if (funct3 == 3'b001) begin
          case (csr)
            12'h7C2: csr_we = 3'b001;
            12'h7C3: csr_we = 3'b010;
            12'h7C4: csr_we = 3'b100;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // PC register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  // Register file; writes to x0 are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (wb_en && rd != 5'd0) begin
      rf_q[rd] <= wb_data;
    end
  end

  // Output CSRs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out0_q <= 32'd0;
      out1_q <= 32'd0;
      out2_q <= 32'd0;
    end else begin
      if (csr_we[0]) out0_q <= rs1_val;
      if (csr_we[1]) out1_q <= rs1_val;
      if (csr_we[2]) out2_q <= rs1_val;
    end
  end

  assign imemreq_val   = rst;
  assign imemreq_addr  = pc_q;
  assign dmemreq_val   = rst & dmem_val;
  assign dmemreq_type  = dmem_wr;
  assign dmemreq_addr  = dmem_addr;
  assign dmemreq_wdata = dmem_wr ? rs2_val : 32'd0;
  assign out0          = out0_q;
  assign out1          = out1_q;
  assign out2          = out2_q;
  assign trace_val     = rst & wb_en & (rd != 5'd0);
  assign trace_addr    = {27'd0, rd};
  assign trace_data    = wb_data;

endmodule

// File: tb/tb_tinyrv1_scycle_proc.sv
// Bench for tinyrv1_scycle_proc: an instruction-level reference model checks every cycle,
// and directed programs pin the model with hand-computed results.
module tb_tinyrv1_scycle_proc;

  logic        clk, rst;
  logic        imemreq_val, dmemreq_val, dmemreq_type, trace_val;
  logic [31:0] imemreq_addr, imemresp_data, dmemreq_addr, dmemreq_wdata, dmemresp_rdata;
  logic [31:0] in0, in1, in2, out0, out1, out2, trace_addr, trace_data;

  tinyrv1_scycle_proc #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
    .in0(in0), .in1(in1), .in2(in2), .out0(out0), .out1(out1), .out2(out2),
    .trace_val(trace_val), .trace_addr(trace_addr), .trace_data(trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench memories: 256-word program, 128-word data store
  logic [31:0] imem [256];
  logic [31:0] dmem [128];
  assign imemresp_data  = imem[imemreq_addr[9:2]];
  assign dmemresp_rdata = dmem[dmemreq_addr[8:2]];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 128; i++) dmem[i] <= 32'd0;
    end else if (dmemreq_val && dmemreq_type) begin
      dmem[dmemreq_addr[8:2]] <= dmemreq_wdata;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] f_addi(int rd, int rs1, int imm);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] f_rr(logic [6:0] f7, int rd, int rs1, int rs2);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] f_lw(int rd, int rs1, int imm);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] f_sw(int rs2, int rs1, int imm);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] f_bne(int rs1, int rs2, int imm);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b001, v[4:1], v[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] f_jal(int rd, int imm);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction
  function automatic logic [31:0] f_jr(int rs1);
    return {12'd0, 5'(rs1), 3'b000, 5'd0, 7'b1100111};
  endfunction
  function automatic logic [31:0] f_csrr(int rd, int csr);
    return {12'(csr), 5'd0, 3'b010, 5'(rd), 7'b1110011};
  endfunction
  function automatic logic [31:0] f_csrw(int csr, int rs1);
    return {12'(csr), 5'(rs1), 3'b001, 5'd0, 7'b1110011};
  endfunction

  // Two's-complement value of an n-bit field
  function automatic logic [31:0] sx(logic [31:0] v, int n);
    return (v >= (32'd1 << (n - 1))) ? v - (32'd1 << n) : v;
  endfunction

  // Reference architectural state
  logic [31:0] m_pc;
  logic [31:0] m_rf [32];
  logic [31:0] m_out [3];
  logic [31:0] m_dmem [128];

  // Per-cycle observations used by the directed checks
  logic [31:0] s_iaddr, s_out0, s_out1;
  logic        s_ival;
  logic [31:0] tr_seen [32];
  int          tr_cnt, bne_taken, bne_not;
  logic        prev_bne;
  logic [31:0] prev_pc, sw_addr, sw_data;

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    for (int i = 0; i < 3; i++) m_out[i] = 32'd0;
    for (int i = 0; i < 128; i++) m_dmem[i] = 32'd0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 32; i++) tr_seen[i] = 32'hDEAD_BEEF;
    tr_cnt = 0; bne_taken = 0; bne_not = 0; prev_bne = 1'b0;
    sw_addr = 32'd0; sw_data = 32'd0;
  endtask

  task automatic load(input logic [31:0] p [$]);
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    foreach (p[i]) imem[i] = p[i];
  endtask

  // One clock: compare DUT against the model at the falling edge, retire in the model at the
  // rising edge.
  task automatic cycle();
    logic [31:0] ins, a, b, pcn, wb, da;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic        wen, dv, dt;
    int          oi;
    @(negedge clk);
    s_iaddr = imemreq_addr; s_ival = imemreq_val; s_out0 = out0; s_out1 = out1;
    if (!rst) begin
      chk("rst_imem_val", {31'd0, imemreq_val}, 32'd0);
      chk("rst_dmem_val", {31'd0, dmemreq_val}, 32'd0);
      chk("rst_trace_val", {31'd0, trace_val}, 32'd0);
      chk("rst_pc", imemreq_addr, 32'd0);
      chk("rst_out0", out0, 32'd0);
      chk("rst_out1", out1, 32'd0);
      chk("rst_out2", out2, 32'd0);
      prev_bne = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      ins = imem[m_pc[9:2]];
      rd  = ins[11:7];
      csr = ins[31:20];
      a   = m_rf[ins[19:15]];
      b   = m_rf[ins[24:20]];
      pcn = m_pc + 32'd4; wen = 1'b0; wb = 32'd0; dv = 1'b0; dt = 1'b0; da = 32'd0; oi = -1;
      case (ins[6:0])
        7'b0110011: if (ins[14:12] == 3'd0) begin
          if (ins[31:25] == 7'd0)      begin wen = 1'b1; wb = a + b; end
          else if (ins[31:25] == 7'd1) begin wen = 1'b1; wb = a * b; end
        end
        7'b0010011: if (ins[14:12] == 3'd0) begin wen = 1'b1; wb = a + sx(ins[31:20], 12); end
        7'b0000011: if (ins[14:12] == 3'd2) begin
          dv = 1'b1; da = a + sx(ins[31:20], 12); wen = 1'b1; wb = m_dmem[da[8:2]];
        end
        7'b0100011: if (ins[14:12] == 3'd2) begin
          dv = 1'b1; dt = 1'b1; da = a + sx(ins[31:25] * 32 + ins[11:7], 12);
        end
        7'b1101111: begin
          wen = 1'b1; wb = m_pc + 32'd4;
          pcn = m_pc + sx(ins[31] * 32'h10_0000 + ins[19:12] * 32'h1000 + ins[20] * 32'h800
                          + ins[30:21] * 2, 21);
        end
        7'b1100111: if (ins[14:12] == 3'd0) pcn = a;
        7'b1100011: if (ins[14:12] == 3'd1 && a != b)
          pcn = m_pc + sx(ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2, 13);
        7'b1110011: begin
          if (ins[14:12] == 3'd2 && csr == 12'hFC2) begin wen = 1'b1; wb = in0; end
          if (ins[14:12] == 3'd2 && csr == 12'hFC3) begin wen = 1'b1; wb = in1; end
          if (ins[14:12] == 3'd2 && csr == 12'hFC4) begin wen = 1'b1; wb = in2; end
          if (ins[14:12] == 3'd1 && csr >= 12'h7C2 && csr <= 12'h7C4) oi = int'(csr - 12'h7C2);
        end
        default: ;
      endcase
      chk("imem_val", {31'd0, imemreq_val}, 32'd1);
      chk("pc", imemreq_addr, m_pc);
      chk("dmem_val", {31'd0, dmemreq_val}, {31'd0, dv});
      if (dv) begin
        chk("dmem_type", {31'd0, dmemreq_type}, {31'd0, dt});
        chk("dmem_addr", dmemreq_addr, da);
      end
      chk("dmem_wdata", dmemreq_wdata, (dv && dt) ? b : 32'd0);
      chk("trace_val", {31'd0, trace_val}, {31'd0, wen && rd != 5'd0});
      if (wen && rd != 5'd0) begin
        chk("trace_addr", trace_addr, {27'd0, rd});
        chk("trace_data", trace_data, wb);
      end
      chk("out0", out0, m_out[0]);
      chk("out1", out1, m_out[1]);
      chk("out2", out2, m_out[2]);
      // Observations for the directed checks
      if (trace_val) begin tr_seen[trace_addr[4:0]] = trace_data; tr_cnt++; end
      if (dmemreq_val && dmemreq_type) begin sw_addr = dmemreq_addr; sw_data = dmemreq_wdata; end
      if (prev_bne) begin
        if (imemreq_addr == prev_pc + 32'd4) bne_not++;
        else bne_taken++;
      end
      prev_bne = (imemresp_data[6:0] == 7'b1100011) && (imemresp_data[14:12] == 3'd1);
      prev_pc  = imemreq_addr;
      @(posedge clk);
      if (wen && rd != 5'd0) m_rf[rd] = wb;
      if (dv && dt) m_dmem[da[8:2]] = b;
      if (oi >= 0) m_out[oi] = a;
      m_pc = pcn;
      #1;
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    model_reset();
    clear_obs();
    repeat (n) cycle();
    rst = 1'b1;
  endtask

  logic [31:0] prog [$];

  initial begin
    rst = 1'b0; in0 = 32'd0; in1 = 32'd0; in2 = 32'd0;
    #1;

    // ALU program, with reset behaviour and the first fetch addresses
    prog = '{f_addi(1, 0, 5), f_addi(2, 0, -3), f_rr(7'd0, 3, 1, 2), f_rr(7'd1, 4, 1, 1),
             f_csrw(12'h7C2, 4)};
    load(prog);
    do_reset(3);
    chk("lit_rst_imem_val", {31'd0, s_ival}, 32'd0);
    chk("lit_rst_out0", s_out0, 32'd0);
    cycle(); chk("lit_pc0", s_iaddr, 32'd0);
    cycle(); chk("lit_pc1", s_iaddr, 32'd4);
    cycle(); chk("lit_pc2", s_iaddr, 32'd8);
    repeat (4) cycle();
    chk("lit_alu_x3", tr_seen[3], 32'd2);
    chk("lit_alu_x4", tr_seen[4], 32'd25);
    chk("lit_alu_out0", s_out0, 32'd25);

    // Mid-program reset restarts from RESET_PC with state cleared
    do_reset(2);
    repeat (2) cycle();
    do_reset(2);
    cycle(); chk("lit_restart_pc", s_iaddr, 32'd0);
    chk("lit_restart_out0", s_out0, 32'd0);
    repeat (6) cycle();
    chk("lit_restart_out0_end", s_out0, 32'd25);

    // Memory
    prog = '{f_addi(1, 0, 32'h100), f_addi(2, 0, 42), f_sw(2, 1, 0), f_lw(3, 1, 0)};
    load(prog);
    do_reset(3);
    repeat (6) cycle();
    chk("lit_sw_addr", sw_addr, 32'h100);
    chk("lit_sw_data", sw_data, 32'd42);
    chk("lit_lw_x3", tr_seen[3], 32'd42);

    // Control flow: bne loop, jal/jr round trip
    prog = '{f_addi(1, 0, 5), f_addi(2, 0, 0), f_bne(1, 0, 8), f_jal(0, 12),
             f_addi(1, 1, -1), f_jal(0, -12), f_jal(1, 12), f_addi(6, 0, 7),
             f_jal(0, 12), f_jr(1)};
    load(prog);
    do_reset(3);
    repeat (30) cycle();
    chk("lit_bne_taken", 32'(bne_taken), 32'd5);
    chk("lit_bne_not", 32'(bne_not), 32'd1);
    chk("lit_jal_link", tr_seen[1], 32'd28);
    chk("lit_after_jr", tr_seen[6], 32'd7);

    // CSR I/O
    in0 = 32'b00011; in1 = 32'b00100; in2 = 32'h0000_00A5;
    prog = '{f_csrr(1, 12'hFC2), f_csrr(2, 12'hFC3), f_rr(7'd0, 3, 1, 2), f_csrw(12'h7C3, 3),
             f_csrr(5, 12'hFC4), f_csrw(12'h7C4, 5)};
    load(prog);
    do_reset(3);
    repeat (4) cycle();
    chk("lit_out1_before", s_out1, 32'd0);
    cycle();
    chk("lit_out1_after", s_out1, 32'd7);
    repeat (3) cycle();
    chk("lit_csr_x3", tr_seen[3], 32'd7);

    // x0 writes, undefined words and unknown CSR/funct are nops
    prog = '{f_addi(0, 0, 9), 32'hFFFF_FFFF, f_addi(7, 0, 3), f_csrw(12'h7C5, 7),
             f_rr(7'd2, 9, 7, 7), f_rr(7'd0, 8, 0, 0)};
    load(prog);
    do_reset(3);
    repeat (6) cycle();
    chk("lit_nop_trace_cnt", 32'(tr_cnt), 32'd2);
    chk("lit_x0_reads_zero", tr_seen[8], 32'd0);
    cycle();
    chk("lit_nop_pc", s_iaddr, 32'd24);
    chk("lit_nop_out0", s_out0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
